// File: rtl/inst_fetch_unit.sv
// Fetch-side producer for the IF->ID fetch buffer: issues icache reads, pairs
// returned words with their PCs in an in-order slot queue, and pushes entries
// downstream. Redirects squash queued work and discard stale in-flight responses.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h1c000000,
   parameter int unsigned QDEPTH     = 4,
   parameter logic [3:0]  ADEF_CODE  = 4'h8,
   parameter logic [3:0]  IFERR_CODE = 4'h9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        excp_flush,
   input  logic [31:0] excp_entry,
   input  logic        ertn_flush,
   input  logic [31:0] era,
   output logic        inst_req_valid,
   input  logic        inst_req_ready,
   output logic [31:0] inst_req_addr,
   input  logic        inst_resp_valid,
   input  logic [31:0] inst_resp_data,
   input  logic        inst_resp_err,
   output logic [63:0] bus_o,
   output logic        excp_o,
   output logic [3:0]  excp_num_o,
   output logic        right_valid,
   input  logic        right_ready
);

   localparam int unsigned AW = $clog2(QDEPTH);
   localparam int unsigned PW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        excp;
      logic [3:0]  num;
      logic        filled;
   } slot_t;

   slot_t         slot_q [QDEPTH];
   slot_t         slot_d [QDEPTH];
   logic [31:0]   pc_q, pc_d;
   logic [PW-1:0] alloc_q, alloc_d;
   logic [PW-1:0] fill_q, fill_d;
   logic [PW-1:0] read_q, read_d;
   logic [PW-1:0] inflight_q, inflight_d;
   logic [PW-1:0] discard_q, discard_d;
   logic          halted_q, halted_d;

   logic          redirect;
   logic [31:0]   target;
   logic [PW-1:0] occ;
   logic          room;
   logic          aligned;
   logic          req_fire;
   logic          adef;
   logic          resp_dec;
   logic          push;
   logic [AW-1:0] ai, fi, ri;

   assign ai = alloc_q[AW-1:0];
   assign fi = fill_q[AW-1:0];
   assign ri = read_q[AW-1:0];

   // Issue/push qualification; outputs stay low while reset is held
   always_comb begin
      redirect       = flush | excp_flush | ertn_flush;
      target         = excp_flush ? excp_entry : (ertn_flush ? era : flush_pc);
      occ            = alloc_q - read_q;
      room           = occ < PW'(QDEPTH);
      aligned        = pc_q[1:0] == 2'b00;
      inst_req_valid = reset & ~redirect & ~halted_q & room
                       & (inflight_q < PW'(QDEPTH)) & aligned;
      inst_req_addr  = pc_q;
      req_fire       = inst_req_valid & inst_req_ready;
      adef           = reset & ~redirect & ~halted_q & room & ~aligned;
      resp_dec       = inst_resp_valid & (inflight_q != '0);
      right_valid    = reset & slot_q[ri].filled & ~redirect;
      push           = right_valid & right_ready;
      bus_o          = {slot_q[ri].pc, slot_q[ri].inst};
      excp_o         = slot_q[ri].excp;
      excp_num_o     = slot_q[ri].excp ? slot_q[ri].num : 4'h0;
   end

   // Next-state: redirect squashes everything, otherwise issue/fill/push all apply
   always_comb begin
      pc_d       = pc_q;
      alloc_d    = alloc_q;
      fill_d     = fill_q;
      read_d     = read_q;
      discard_d  = discard_q;
      halted_d   = halted_q;
      inflight_d = inflight_q + PW'(req_fire) - PW'(resp_dec);
      for (int i = 0; i < QDEPTH; i++) slot_d[i] = slot_q[i];

      if (redirect) begin
         pc_d      = target;
         alloc_d   = '0;
         fill_d    = '0;
         read_d    = '0;
         halted_d  = 1'b0;
         discard_d = inflight_q - PW'(resp_dec);
         for (int i = 0; i < QDEPTH; i++) slot_d[i] = '0;
      end else begin
         if (req_fire) begin
            slot_d[ai]        = '0;
            slot_d[ai].pc     = pc_q;
            alloc_d           = alloc_q + PW'(1);
            pc_d              = pc_q + 32'd4;
         end
         if (adef) begin
            slot_d[ai]        = '0;
            slot_d[ai].pc     = pc_q;
            slot_d[ai].excp   = 1'b1;
            slot_d[ai].num    = ADEF_CODE;
            slot_d[ai].filled = 1'b1;
            alloc_d           = alloc_q + PW'(1);
            halted_d          = 1'b1;
         end
         if (inst_resp_valid) begin
            if (discard_q != '0) begin
               discard_d = discard_q - PW'(1);
            end else begin
               slot_d[fi].inst   = inst_resp_data;
               slot_d[fi].filled = 1'b1;
               if (inst_resp_err) begin
                  slot_d[fi].excp = 1'b1;
                  slot_d[fi].num  = IFERR_CODE;
                  halted_d        = 1'b1;
               end
               fill_d = fill_q + PW'(1);
            end
         end
         if (push) begin
            slot_d[ri].filled = 1'b0;
            read_d            = read_q + PW'(1);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         alloc_q    <= '0;
         fill_q     <= '0;
         read_q     <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
         halted_q   <= 1'b0;
         for (int i = 0; i < QDEPTH; i++) slot_q[i] <= '0;
      end else begin
         pc_q       <= pc_d;
         alloc_q    <= alloc_d;
         fill_q     <= fill_d;
         read_q     <= read_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         halted_q   <= halted_d;
         for (int i = 0; i < QDEPTH; i++) slot_q[i] <= slot_d[i];
      end
   end

endmodule
